// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the write-back arbiter.
//   wb_src_t     - index of each write-back source in req/gnt/rd_in
//   arb_state_t  - arbiter state (NORMAL / STARVE)
//   NUM_WB_REQ   - number of write-back requesters
//   RD_W         - register-file destination width
//   onehot_to_idx - converts a one-hot grant into the source index
package wb_pkg;

  localparam int NUM_WB_REQ = 5;
  localparam int RD_W       = 5;

  typedef enum logic [2:0] {
    WB_PIPE = 3'd0,
    WB_MUL  = 3'd1,
    WB_DIV  = 3'd2,
    WB_LOAD = 3'd3,
    WB_CSR  = 3'd4
  } wb_src_t;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_STARVE = 1'b1
  } arb_state_t;

  // OR-reduction encoder; only meaningful for one-hot (or zero) input.
  function automatic logic [2:0] onehot_to_idx(input logic [NUM_WB_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_WB_REQ; i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: purely combinational 4-way round-robin arbiter.
//   req [3:0] - request per slot
//   ptr [1:0] - slot with highest priority this cycle
//   gnt [3:0] - one-hot grant (zero when no request)
module rr_arbiter4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [3:0] gnt
);

  logic [1:0] idx;
  logic       found;

  // Scan slots starting at ptr, wrapping; first requesting slot wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int off = 0; off < 4; off++) begin
      idx = ptr + 2'(off);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: register-file write-back port arbiter for five sources.
//   clk        - system clock
//   reset_n    - synchronous active-low reset
//   req        - write-back request per source (bit0 = pipeline retire)
//   rd_in      - destination register per source
//   gnt        - combinational one-hot grant
//   stall_pipe - retire stage must hold (req[0] high but not granted)
//   wb_sel     - registered result-mux select (index of last grant)
//   rf_we      - registered register-file write enable
//   rf_rd      - registered register-file destination
// The pipeline retire port has fixed priority; sources 1-4 share round-robin.
// A source 1-4 that has waited STARVE_LIMIT cycles gets one forced grant
// ahead of the pipeline.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_WB_REQ-1:0]            req,
  input  logic [NUM_WB_REQ-1:0][RD_W-1:0]  rd_in,
  output logic [NUM_WB_REQ-1:0]            gnt,
  output logic                             stall_pipe,
  output logic [2:0]                       wb_sel,
  output logic                             rf_we,
  output logic [RD_W-1:0]                  rf_rd
);

  localparam logic [3:0] LIMIT4 = 4'(STARVE_LIMIT);

  arb_state_t               state_reg, state_next;
  logic [2:0]               rr_ptr_reg, rr_ptr_next;   // holds 1..4
  logic [1:0]               rr_ptr_idx;
  logic [3:0]               rr_gnt;
  logic [NUM_WB_REQ-1:1]    hit_next;                  // counter reaches limit at next edge
  logic [NUM_WB_REQ-1:1]    starve_now;                // currently starved and still requesting
  logic [NUM_WB_REQ-1:1]    starve_pick;
  logic [2:0]               gnt_idx;
  logic [RD_W-1:0]          gnt_rd;
  logic [2:0]               wb_sel_reg;
  logic                     rf_we_reg;
  logic [RD_W-1:0]          rf_rd_reg;

  // Pointer value 1..4 maps onto arbiter slot 0..3 (4 wraps to slot 3).
  assign rr_ptr_idx = rr_ptr_reg[1:0] - 2'd1;

  rr_arbiter4 u_rr (
    .req (req[NUM_WB_REQ-1:1]),
    .ptr (rr_ptr_idx),
    .gnt (rr_gnt)
  );

  // Isolate lowest set bit: lowest-index starved requester wins.
  assign starve_pick = starve_now & (~starve_now + 4'd1);

  // Wait counters for the round-robin sources.
  genvar gi;
  generate
    for (gi = 1; gi < NUM_WB_REQ; gi++) begin : g_wait
      logic [3:0] cnt_reg, cnt_next;

      always_comb begin
        cnt_next = cnt_reg;
        if (!req[gi] || gnt[gi]) begin
          cnt_next = '0;
        end else if (cnt_reg != 4'hF) begin
          cnt_next = cnt_reg + 4'd1;
        end
      end

      always_ff @(posedge clk) begin
        if (!reset_n) cnt_reg <= '0;
        else          cnt_reg <= cnt_next;
      end

      assign hit_next[gi]   = (cnt_next >= LIMIT4);
      assign starve_now[gi] = req[gi] && (cnt_reg >= LIMIT4);
    end
  endgenerate

  // Grant selection. If the starved source dropped its request, STARVE
  // falls back to normal arbitration rather than granting nobody.
  always_comb begin
    gnt = '0;
    if (reset_n) begin
      if (state_reg == ST_STARVE && |starve_now) begin
        gnt[NUM_WB_REQ-1:1] = starve_pick;
      end else if (req[WB_PIPE]) begin
        gnt[WB_PIPE] = 1'b1;
      end else begin
        gnt[NUM_WB_REQ-1:1] = rr_gnt;
      end
    end
    stall_pipe = reset_n & req[WB_PIPE] & ~gnt[WB_PIPE];
  end

  // Next state and round-robin pointer.
  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    case (state_reg)
      ST_NORMAL: if (|hit_next) state_next = ST_STARVE;
      ST_STARVE: state_next = ST_NORMAL;
      default:   state_next = ST_NORMAL;
    endcase
    for (int k = 1; k < NUM_WB_REQ; k++) begin
      if (gnt[k]) rr_ptr_next = (k == NUM_WB_REQ - 1) ? 3'd1 : 3'(k + 1);
    end
  end

  assign gnt_idx = onehot_to_idx(gnt);
  assign gnt_rd  = rd_in[gnt_idx];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg  <= ST_NORMAL;
      rr_ptr_reg <= 3'd1;
      wb_sel_reg <= '0;
      rf_rd_reg  <= '0;
      rf_we_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      if (|gnt) begin
        wb_sel_reg <= gnt_idx;
        rf_rd_reg  <= gnt_rd;
        rf_we_reg  <= |gnt_rd;   // x0 destination completes handshake without a write
      end else begin
        rf_we_reg  <= 1'b0;
      end
    end
  end

  assign wb_sel = wb_sel_reg;
  assign rf_rd  = rf_rd_reg;
  assign rf_we  = rf_we_reg;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: directed vectors push expected grants
// and write-back results; a negedge monitor pops and compares.
module tb_wb_arbiter;
  localparam int LIMIT = 8;
  // Worst case: all four round-robin sources starve together while the
  // pipeline keeps requesting, so STARVE/NORMAL alternate three times.
  localparam int WAIT_BOUND = LIMIT + 6;

  logic             clk;
  logic             reset_n;
  logic [4:0]       req;
  logic [4:0][4:0]  rd_in;
  logic [4:0]       gnt;
  logic             stall_pipe;
  logic [2:0]       wb_sel;
  logic             rf_we;
  logic [4:0]       rf_rd;

  typedef struct {
    int         cyc;
    logic [4:0] gnt;
    logic       stall;
    logic [2:0] sel;
    logic [4:0] rd;
    logic       we;
  } exp_t;

  exp_t sb_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   drain_cyc = -1;
  bit   rand_mode = 0;

  wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .rd_in(rd_in),
    .gnt(gnt), .stall_pipe(stall_pipe), .wb_sel(wb_sel),
    .rf_we(rf_we), .rf_rd(rf_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, expv);
    end
  endfunction

  task automatic step(input logic [4:0] r);
    @(posedge clk);
    #1;
    req = r;
  endtask

  task automatic expect_gnt(input logic [4:0] g, input logic st, input logic [2:0] s,
                            input logic [4:0] rd, input logic we);
    sb_q.push_back('{cyc, g, st, s, rd, we});
  endtask

  // Monitor
  initial begin : monitor
    bit         have_ref = 0;
    logic [2:0] ref_sel = '0;
    logic [4:0] ref_rd = '0;
    logic       ref_we = 1'b0;
    int         wait_cnt [5];
    exp_t       e;
    for (int i = 0; i < 5; i++) wait_cnt[i] = 0;
    forever begin
      @(negedge clk);
      if (cyc == drain_cyc) chk("sb_drain", sb_q.size(), 0);
      if (rand_mode) begin
        have_ref = 0;
        chk("gnt_onehot", int'($onehot0(gnt)), 1);
        chk("wb_sel_range", int'(wb_sel <= 3'd4), 1);
        chk("rand_stall", int'(stall_pipe), int'(req[0] && !gnt[0]));
        for (int i = 1; i < 5; i++) begin
          if (gnt[i]) begin
            chk("wait_bound", int'(wait_cnt[i] <= WAIT_BOUND), 1);
            wait_cnt[i] = 0;
          end else if (req[i]) begin
            wait_cnt[i]++;
          end else begin
            wait_cnt[i] = 0;
          end
        end
      end else begin
        if (have_ref) begin
          chk("wb_sel", int'(wb_sel), int'(ref_sel));
          chk("rf_rd", int'(rf_rd), int'(ref_rd));
          chk("rf_we", int'(rf_we), int'(ref_we));
        end
        if (!reset_n) begin
          chk("rst_gnt", int'(gnt), 0);
          chk("rst_stall", int'(stall_pipe), 0);
          ref_sel = '0; ref_rd = '0; ref_we = 1'b0;
        end else if (gnt != 5'b0) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_gnt", int'(gnt), 0);
            ref_we = 1'b0;
          end else begin
            e = sb_q.pop_front();
            chk("sb_cyc", cyc, e.cyc);
            chk("sb_gnt", int'(gnt), int'(e.gnt));
            chk("sb_stall", int'(stall_pipe), int'(e.stall));
            ref_sel = e.sel; ref_rd = e.rd; ref_we = e.we;
            $display("txn cyc=%0d gnt=%b stall=%b exp_sel=%0d exp_rd=%0d exp_we=%b",
                     cyc, gnt, stall_pipe, e.sel, e.rd, e.we);
          end
        end else begin
          chk("idle_stall", int'(stall_pipe), 0);
          ref_we = 1'b0;
        end
        have_ref = 1;
      end
    end
  end

  // Stimulus
  initial begin : stim
    logic [4:0] g;
    reset_n = 1'b0;
    req     = '0;
    rd_in   = '0;
    repeat (3) step(5'b00000);
    reset_n = 1'b1;

    // Pipeline retire alone
    rd_in[0] = 5'd5;
    step(5'b00001); expect_gnt(5'b00001, 0, 3'd0, 5'd5, 1);
    step(5'b00000);

    // Round-robin rotation from pointer 1
    rd_in[1] = 5'd11; rd_in[2] = 5'd12; rd_in[3] = 5'd13; rd_in[4] = 5'd14;
    step(5'b11110); expect_gnt(5'b00010, 0, 3'd1, 5'd11, 1);
    step(5'b11110); expect_gnt(5'b00100, 0, 3'd2, 5'd12, 1);
    step(5'b11110); expect_gnt(5'b01000, 0, 3'd3, 5'd13, 1);
    step(5'b11110); expect_gnt(5'b10000, 0, 3'd4, 5'd14, 1);
    step(5'b11110); expect_gnt(5'b00010, 0, 3'd1, 5'd11, 1);
    step(5'b00000);

    // Grant to destination x0: no write
    rd_in[3] = 5'd0;
    step(5'b01000); expect_gnt(5'b01000, 0, 3'd3, 5'd0, 0);
    step(5'b00000);

    // Starvation of requester 2 behind the pipeline
    for (int k = 0; k < 8; k++) begin
      step(5'b00101); expect_gnt(5'b00001, 0, 3'd0, 5'd5, 1);
    end
    step(5'b00101); expect_gnt(5'b00100, 1, 3'd2, 5'd12, 1);
    step(5'b00101); expect_gnt(5'b00001, 0, 3'd0, 5'd5, 1);
    step(5'b00000);

    // Release in the cycle the counter would hit the limit: no STARVE
    for (int k = 0; k < 7; k++) begin
      step(5'b00101); expect_gnt(5'b00001, 0, 3'd0, 5'd5, 1);
    end
    step(5'b00001); expect_gnt(5'b00001, 0, 3'd0, 5'd5, 1);
    step(5'b00101); expect_gnt(5'b00001, 0, 3'd0, 5'd5, 1);
    step(5'b00101); expect_gnt(5'b00001, 0, 3'd0, 5'd5, 1);
    step(5'b00000);

    // Reset in the cycle requester 1 would be granted
    for (int k = 0; k < 3; k++) begin
      step(5'b00101); expect_gnt(5'b00001, 0, 3'd0, 5'd5, 1);
    end
    step(5'b00110); reset_n = 1'b0;
    step(5'b00110); reset_n = 1'b1; expect_gnt(5'b00010, 0, 3'd1, 5'd11, 1);
    for (int k = 0; k < 7; k++) begin
      step(5'b00101); expect_gnt(5'b00001, 0, 3'd0, 5'd5, 1);
    end
    step(5'b00101); expect_gnt(5'b00100, 1, 3'd2, 5'd12, 1);
    step(5'b00001); expect_gnt(5'b00001, 0, 3'd0, 5'd5, 1);
    step(5'b00000);
    step(5'b00000);
    drain_cyc = cyc;
    step(5'b00000);

    // Randomised protocol-respecting requesters
    rand_mode = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      g = gnt;
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
        if (req[i]) begin
          if (g[i]) begin
            req[i] = 1'($urandom_range(0, 1));
            rd_in[i] = 5'($urandom_range(0, 31));
          end
        end else if ($urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          rd_in[i] = 5'($urandom_range(0, 31));
        end
      end
    end
    @(posedge clk);
    #1;
    rand_mode = 1'b0;
    reset_n = 1'b0;
    req = '0;
    step(5'b00000);
    reset_n = 1'b1;
    step(5'b00000);
    step(5'b00000);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
